// File: rtl/alu_phase_decoder.sv
// Purpose : infers which of the six rotating ALU operations is active, locks onto the
//           rotation and flags every enabled locked cycle whose result disagrees.
// Latency : inputs registered once; lock, op_idx and mismatch update one edge after evaluation.
// Backpressure: none; ena=0 freezes all state and forces mismatch low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          clock enable (disabled cycles do not count toward dwell)
//   a, b, r      ALU operands and ALU result bus
//   op_idx       decoded operation (0 SUM,1 SUB,2 AND,3 OR,4 SHL,5 SHR)
//   locked       high while locked onto the rotation
//   mismatch     one-cycle pulse after a locked cycle whose result was wrong
//   err_count    saturating count of mismatch pulses, cleared only by reset
module alu_phase_decoder #(
   parameter int DWELL      = 100_000_000,
   parameter int CNT_W      = 27,
   parameter int MISS_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] r,
   output logic [2:0] op_idx,
   output logic       locked,
   output logic       mismatch,
   output logic [7:0] err_count
);

   localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

   typedef enum logic [1:0] {SEARCH, PRE, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [7:0]        sa, sb, sr;
   logic [2:0]        cand_q, cand_d;
   logic [2:0]        op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
   logic              mm_q, mm_d;
   logic [7:0]        err_q, err_d;

   logic [5:0]        match;
   logic              any_match;
   logic              uniq;
   logic [2:0]        match_idx;

   function automatic logic [2:0] next_op(input logic [2:0] x);
      return (x == 3'd5) ? 3'd0 : x + 3'd1;
   endfunction

   // Candidate results for every operation, compared against the sampled result bus.
   always_comb begin
      match[0] = (sr == 8'(sa + sb));
      match[1] = (sr == 8'(sa - sb));
      match[2] = (sr == (sa & sb));
      match[3] = (sr == (sa | sb));
      match[4] = (sr == {sa[6:0], 1'b0});
      match[5] = (sr == {1'b0, sa[7:1]});
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   always_comb begin
      any_match = (match != 6'd0);
      uniq      = any_match && ((match & (match - 6'd1)) == 6'd0);
      match_idx = 3'd0;
      for (int k = 0; k < 6; k++) begin
         if (match[k]) begin
            match_idx = 3'(k);
         end
      end
   end

   assign miss_inc = miss_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      mm_d    = 1'b0;
      err_d   = err_q;
      case (state_q)
         SEARCH: begin
            if (uniq) begin
               cand_d  = match_idx;
               state_d = PRE;
            end
         end
         PRE: begin
            if (uniq) begin
               if (match_idx == next_op(cand_q)) begin
                  // The rotation stepped to the successor: this is the first cycle of a phase.
                  state_d = LOCKED;
                  op_d    = match_idx;
                  cnt_d   = CNT_W'(1);
                  miss_d  = '0;
               end else begin
                  cand_d = match_idx;
               end
            end else if (!any_match) begin
               state_d = SEARCH;
            end
         end
         LOCKED: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               op_d  = next_op(op_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            // Judged against the current (pre-wrap) op_q; a wrap above still applies.
            if (match[op_q]) begin
               miss_d = '0;
            end else begin
               mm_d = 1'b1;
               if (err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
               if (miss_inc == MISS_MAX) begin
                  state_d = SEARCH;
                  miss_d  = '0;
                  cnt_d   = '0;
               end else begin
                  miss_d = miss_inc;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEARCH;
         sa      <= '0;
         sb      <= '0;
         sr      <= '0;
         cand_q  <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         miss_q  <= '0;
         mm_q    <= 1'b0;
         err_q   <= '0;
      end else if (ena) begin
         state_q <= state_d;
         sa      <= a;
         sb      <= b;
         sr      <= r;
         cand_q  <= cand_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         miss_q  <= miss_d;
         mm_q    <= mm_d;
         err_q   <= err_d;
      end else begin
         // Drop any pending pulse so it cannot reappear when ena returns.
         mm_q <= 1'b0;
      end
   end

   assign op_idx    = op_q;
   assign locked    = (state_q == LOCKED);
   assign mismatch  = mm_q & ena;
   assign err_count = err_q;

endmodule

// File: tb/tb_alu_phase_decoder.sv
// Bench for alu_phase_decoder with DWELL=8: directed ALU rotation, corruption, lock loss,
// enable hold, asynchronous reset and ambiguous operands. Expected outputs are queued
// per clock edge by the stimulus and compared by a separate negedge monitor.
module tb_alu_phase_decoder;

   localparam int DW = 8;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] a, b, r;
   logic [2:0] op_idx;
   logic       locked;
   logic       mismatch;
   logic [7:0] err_count;

   alu_phase_decoder #(.DWELL(DW), .CNT_W(4), .MISS_LIMIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .a         (a),
      .b         (b),
      .r         (r),
      .op_idx    (op_idx),
      .locked    (locked),
      .mismatch  (mismatch),
      .err_count (err_count)
   );

   typedef struct {
      int unsigned edg;
      logic        lk;
      logic [2:0]  op;
      logic        mm;
      logic [7:0]  err;
      int          scen;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned edge_n = 0;
   int          checks = 0;
   int          errors = 0;
   int          rot    = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic string scen_name(input int s);
      case (s)
         1: return "clean_lock";
         2: return "single_corrupt";
         3: return "lock_loss";
         4: return "ambiguous";
         5: return "enable_hold";
         6: return "relock_after_reset";
         7: return "reset_async";
         8: return "reset_state";
         default: return "other";
      endcase
   endfunction

   // ALU model for a=0x35, b=0x0F: rotation SUM,SUB,AND,OR,SHL,SHR with 8-cycle dwell.
   function automatic logic [7:0] rot_r(input int j);
      case ((j / DW) % 6)
         0: return 8'h44;
         1: return 8'h26;
         2: return 8'h05;
         3: return 8'h3F;
         4: return 8'h6A;
         default: return 8'h1A;
      endcase
   endfunction

   // When locked in step with the rotation, op_idx after evaluating sample j
   // is the phase of sample j+1.
   function automatic logic [2:0] rot_op(input int j);
      return 3'(((j + 1) / DW) % 6);
   endfunction

   task automatic check_out(input int scen, input int unsigned ed, input logic lk,
                            input logic [2:0] op, input logic mm, input logic [7:0] err);
      checks++;
      if ({locked, op_idx, mismatch, err_count} !== {lk, op, mm, err}) begin
         errors++;
         $display("FAIL %s edge %0d: got locked=%0b op_idx=%0d mismatch=%0b err_count=%0d, want locked=%0b op_idx=%0d mismatch=%0b err_count=%0d",
                  scen_name(scen), ed, locked, op_idx, mismatch, err_count, lk, op, mm, err);
      end
   endtask

   // Drive one cycle of r; the response appears after the edge following the sampling edge.
   task automatic cyc(input logic [7:0] rv, input logic e_lk, input logic [2:0] e_op,
                      input logic e_mm, input logic [7:0] e_err, input int scen);
      exp_t e;
      r     = rv;
      e.edg = edge_n + 2;
      e.lk  = e_lk;
      e.op  = e_op;
      e.mm  = e_mm;
      e.err = e_err;
      e.scen = scen;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run_locked(input int n, input logic [7:0] e_err, input int scen);
      for (int i = 0; i < n; i++) begin
         cyc(rot_r(rot), 1'b1, rot_op(rot), 1'b0, e_err, scen);
         rot++;
      end
   endtask

   task automatic acquire(input int scen);
      for (int i = 0; i < DW; i++) begin
         cyc(rot_r(rot), 1'b0, 3'd0, 1'b0, 8'd0, scen);
         rot++;
      end
   endtask

   // Monitor: compares every queued expectation at the negedge after its edge.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].edg <= edge_n) begin
         mon_e = sb_q.pop_front();
         if (mon_e.edg < edge_n) begin
            checks++;
            errors++;
            $display("FAIL %s edge %0d: expectation not compared in time (now edge %0d)",
                     scen_name(mon_e.scen), mon_e.edg, edge_n);
         end else begin
            check_out(mon_e.scen, mon_e.edg, mon_e.lk, mon_e.op, mon_e.mm, mon_e.err);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      ena   = 1'b1;
      a     = 8'h00;
      b     = 8'h00;
      r     = 8'h00;
      #1 rst_n = 1'b0;
      #2 check_out(8, edge_n, 1'b0, 3'd0, 1'b0, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Clean lock, then three full rotations with no errors.
      a = 8'h35;
      b = 8'h0F;
      rot = 0;
      acquire(1);
      run_locked(3 * 6 * DW, 8'd0, 1);

      // Lock loss: four consecutive misses mid-phase (SUB), relock at next boundary.
      run_locked(2, 8'd0, 3);
      for (int k = 0; k < 4; k++) begin
         cyc(8'hFF, (k < 3), 3'd1, 1'b1, 8'(k + 1), 3);
         rot++;
      end
      cyc(rot_r(rot), 1'b0, 3'd1, 1'b0, 8'd4, 3);
      rot++;
      cyc(rot_r(rot), 1'b0, 3'd1, 1'b0, 8'd4, 3);
      rot++;
      run_locked(34, 8'd4, 3);

      // Single corruption while on SUM.
      cyc(8'h00, 1'b1, rot_op(rot), 1'b1, 8'd5, 2);
      rot++;
      run_locked(8, 8'd5, 2);

      // Enable hold mid-phase with arbitrary r; dwell must resume where it left off.
      ena = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc(8'hA0 + 8'(k), 1'b1, rot_op(rot - 1), 1'b0, 8'd5, 5);
      end
      ena = 1'b1;
      run_locked(17, 8'd5, 5);

      // Asynchronous reset mid-phase with err_count = 5.
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_out(7, edge_n, 1'b0, 3'd0, 1'b0, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Ambiguous operands: every operation yields 0x00.
      a = 8'h00;
      b = 8'h00;
      for (int k = 0; k < 20; k++) begin
         cyc(8'h00, 1'b0, 3'd0, 1'b0, 8'd0, 4);
      end

      // Real operands again: lock exactly as in the clean case.
      a = 8'h35;
      b = 8'h0F;
      rot = 0;
      acquire(6);
      run_locked(30, 8'd0, 6);

      repeat (3) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
